phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 Parameter: FETCH_WAIT, default 1, instruction-memory read latency in clock cycles (legal range 1..3).
REQ-002 The block SHALL have port: clk  input  1  rising-edge system clock.
REQ-003 The block SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port: run  input  1  level; allows leaving IDLE.
REQ-005 The block SHALL have port: imem_q  input  16  instruction-memory read data.
REQ-006 The block SHALL have port: instr  output  16  instruction register, driven to the decoder.
REQ-007 The block SHALL have ports fe, e1 and e2: each output, 1 bit, a one-hot phase strobe to the decoder.
REQ-008 The block SHALL have port: halted  output  1  high while in HALT.
REQ-009 The block SHALL have port: instr_count  output  16  count of retired instructions.

Function
REQ-010 The FSM SHALL have exactly these states: IDLE, FETCH, WAIT, EXEC1, EXEC2, HALT.
REQ-011 Strobes SHALL be Moore outputs: fe=1 only in FETCH and WAIT; e1=1 only in EXEC1; e2=1 only in EXEC2; all 0 elsewhere.
REQ-012 At most one of fe/e1/e2 SHALL be high in any cycle.
REQ-013 IDLE->FETCH SHALL occur when run=1; otherwise the FSM stays in IDLE.
REQ-014 FETCH SHALL last 1 cycle, followed by WAIT for FETCH_WAIT-1 cycles, then EXEC1; when FETCH_WAIT=1, WAIT is skipped.
REQ-015 instr SHALL load imem_q on the last fe cycle, i.e. the edge entering EXEC1; instr SHALL hold its value in all other cycles.
REQ-016 EXEC1->EXEC2 SHALL occur when instr is a two-phase opcode: instr[15:13]=3'b110 (load-direct) or instr[15:11]=5'b01110 (load-register).
REQ-017 EXEC1->HALT SHALL occur when instr[15:11]=5'b00000 (stop); EXEC1 SHALL still be asserted for that one cycle.
REQ-018 Any other opcode SHALL make EXEC1 go to FETCH if run=1, else to IDLE.
REQ-019 EXEC2 SHALL go to FETCH if run=1, else to IDLE.
REQ-020 run deasserting mid-instruction SHALL NOT abort it; run is sampled only in IDLE, EXEC1 (non-halting) and EXEC2.
REQ-021 HALT SHALL be absorbing; only reset_n exits it.
REQ-022 instr_count SHALL increment by 1 on the clock edge leaving the instruction's final execute phase (EXEC1 for one-phase instructions, EXEC2 for two-phase).
REQ-023 The stop instruction SHALL also increment instr_count.
REQ-024 instr_count SHALL wrap from 16'hFFFF to 16'h0000 without any flag.
REQ-025 Best-case throughput SHALL be one one-phase instruction per 1+FETCH_WAIT cycles.

Reset
REQ-026 Asserting reset_n=0 SHALL immediately, without a clock edge, force: state=IDLE, instr=16'h0000, fe=e1=e2=0, halted=0, instr_count=0.
REQ-027 Reset asserted in any state, including mid-fetch or EXEC2, SHALL discard the in-flight instruction and leave instr_count unincremented.
REQ-028 After reset_n deasserts, the first FETCH SHALL be entered on the first rising edge with run=1.

Configuration
REQ-029 Macro: PHASE_SEQUENCER_STEP_EN.
REQ-030 When PHASE_SEQUENCER_STEP_EN is defined, an extra input port "step  input  1  single-step request" SHALL exist; the FSM SHALL replace every run-sampled transition to FETCH with a transition to IDLE, and IDLE->FETCH SHALL require a step=1 pulse (run ignored).
REQ-031 When PHASE_SEQUENCER_STEP_EN is undefined, the step port SHALL be absent and behaviour SHALL be exactly REQ-013..REQ-025.

Verification
REQ-032 FETCH_WAIT=1, run=1, imem_q=16'h8805 (load-immediate) -> fe high 1 cycle, e1 high next cycle, instr=16'h8805 during e1, no e2, instr_count=1.
REQ-033 imem_q=16'hC003 (load-direct) -> fe, e1, e2 each high for exactly one consecutive cycle; instr_count increments after e2.
REQ-034 imem_q=16'h0000 -> one e1 cycle, then halted=1 with fe/e1/e2 held 0 for 20 cycles regardless of run; reset_n pulse -> IDLE, halted=0.
REQ-035 FETCH_WAIT=3 -> fe high exactly 3 cycles before each e1; reset_n asserted during the 2nd fe cycle -> all outputs 0 asynchronously, instr_count unchanged at 0.
REQ-036 Preload instr_count 16'hFFFF (via 65535 one-phase instructions) -> next retire gives instr_count=16'h0000.
REQ-037 With PHASE_SEQUENCER_STEP_EN defined, run=1 and no step -> remains in IDLE; one step pulse -> exactly one instruction executes, then returns to IDLE.

Source files
------------

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - fetch/execute phase sequencer; PHASE_SEQUENCER_STEP_EN adds single-step mode
module phase_sequencer #(
  parameter int FETCH_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
`ifdef PHASE_SEQUENCER_STEP_EN
  input  logic        step,
`endif
  input  logic [15:0] imem_q,
  output logic [15:0] instr,
  output logic        fe,
  output logic        e1,
  output logic        e2,
  output logic        halted,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_EXEC1, S_EXEC2, S_HALT
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(FETCH_WAIT - 2);

  state_t      state_q, state_d;
  logic [1:0]  wait_q, wait_d;
  logic [15:0] instr_q, count_q;
  logic        start, resume, two_phase, is_stop, load, retire;

`ifdef PHASE_SEQUENCER_STEP_EN
  // Single-step: every instruction ends back in IDLE and waits for the next pulse.
  assign start  = step;
  assign resume = 1'b0;
`else
  assign start  = run;
  assign resume = run;
`endif

  assign two_phase = (instr_q[15:13] == 3'b110) || (instr_q[15:11] == 5'b01110);
  assign is_stop   = (instr_q[15:11] == 5'b00000);
  assign load      = fe && (state_d == S_EXEC1);
  assign retire    = ((state_q == S_EXEC1) && !two_phase) || (state_q == S_EXEC2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      instr_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (load)   instr_q <= imem_q;
      if (retire) count_q <= count_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: begin
        wait_d  = '0;
        state_d = (FETCH_WAIT > 1) ? S_WAIT : S_EXEC1;
      end
      S_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = S_EXEC1;
        else                     wait_d  = wait_q + 2'd1;
      end
      S_EXEC1: begin
        if (is_stop)        state_d = S_HALT;
        else if (two_phase) state_d = S_EXEC2;
        else                state_d = resume ? S_FETCH : S_IDLE;
      end
      S_EXEC2: state_d = resume ? S_FETCH : S_IDLE;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fe          = (state_q == S_FETCH) || (state_q == S_WAIT);
    e1          = (state_q == S_EXEC1);
    e2          = (state_q == S_EXEC2);
    halted      = (state_q == S_HALT);
    instr       = instr_q;
    instr_count = count_q;
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - self-checking bench for phase_sequencer (FETCH_WAIT 1 and 3)
`timescale 1ns/1ps
module tb_phase_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic [15:0] imem_q = 16'h0000;
`ifdef PHASE_SEQUENCER_STEP_EN
  logic        step = 1'b0;
  localparam bit STEP = 1'b1;
`else
  localparam bit STEP = 1'b0;
`endif

  logic [15:0] instr1, cnt1, instr3, cnt3;
  logic        fe1, e11, e21, h1, fe3, e13, e23, h3;
  logic [3:0]  o [2];
  logic [15:0] oi [2];
  logic [15:0] oc [2];

  assign o[0]  = {fe1, e11, e21, h1};
  assign o[1]  = {fe3, e13, e23, h3};
  assign oi[0] = instr1;
  assign oi[1] = instr3;
  assign oc[0] = cnt1;
  assign oc[1] = cnt3;

  always #5 clk = ~clk;

  phase_sequencer #(.FETCH_WAIT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .run(run),
`ifdef PHASE_SEQUENCER_STEP_EN
    .step(step),
`endif
    .imem_q(imem_q), .instr(instr1), .fe(fe1), .e1(e11), .e2(e21),
    .halted(h1), .instr_count(cnt1)
  );

  phase_sequencer #(.FETCH_WAIT(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .run(run),
`ifdef PHASE_SEQUENCER_STEP_EN
    .step(step),
`endif
    .imem_q(imem_q), .instr(instr3), .fe(fe3), .e1(e13), .e2(e23),
    .halted(h3), .instr_count(cnt3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Reference model: a queue of upcoming phases (1=fetch,2=exec1,3=exec2) per instance.
  localparam int FW [2] = '{1, 3};
  int          sched [2][$];
  bit          m_halt [2];
  logic [15:0] m_instr [2];
  logic [15:0] m_cnt [2];

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      sched[k].delete();
      m_halt[k]  = 1'b0;
      m_instr[k] = 16'h0000;
      m_cnt[k]   = 16'h0000;
    end
  endfunction

  function automatic void push_instr(int k);
    repeat (FW[k]) sched[k].push_back(1);
    sched[k].push_back(2);
  endfunction

  function automatic void m_step(bit start_req, bit cont, logic [15:0] q);
    int h;
    for (int k = 0; k < 2; k++) begin
      if (m_halt[k]) continue;
      if (sched[k].size() == 0) begin
        if (start_req) push_instr(k);
        continue;
      end
      h = sched[k].pop_front();
      if (h == 1) begin
        if (sched[k].size() > 0 && sched[k][0] == 2) m_instr[k] = q;
      end else if (h == 2) begin
        if (m_instr[k][15:11] == 5'b00000) begin
          m_cnt[k]++;
          m_halt[k] = 1'b1;
        end else if (m_instr[k][15:13] == 3'b110 || m_instr[k][15:11] == 5'b01110) begin
          sched[k].push_back(3);
        end else begin
          m_cnt[k]++;
          if (cont) push_instr(k);
        end
      end else begin
        m_cnt[k]++;
        if (cont) push_instr(k);
      end
    end
  endfunction

  function automatic logic [3:0] m_out(int k);
    int h;
    h = (sched[k].size() > 0) ? sched[k][0] : 0;
    return {h == 1, h == 2, h == 3, m_halt[k]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    run     = 1'b0;
    imem_q  = 16'h0000;
`ifdef PHASE_SEQUENCER_STEP_EN
    step    = 1'b0;
`endif
    #2 reset_n = 1'b1;
  endtask

  task automatic go(logic [15:0] op);
    run    = 1'b1;
    imem_q = op;
`ifdef PHASE_SEQUENCER_STEP_EN
    step   = 1'b1;
`endif
  endtask

  task automatic stop_go();
    run = 1'b0;
`ifdef PHASE_SEQUENCER_STEP_EN
    step = 1'b0;
`endif
  endtask

  typedef struct {
    logic [15:0] op;
    logic        exp_e2;
    logic        exp_halt;
  } vec_t;

  vec_t vecs [10];
  int   nfe;

  initial begin
    vecs[0] = '{16'h8805, 1'b0, 1'b0};
    vecs[1] = '{16'hC003, 1'b1, 1'b0};
    vecs[2] = '{16'hDFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h7000, 1'b1, 1'b0};
    vecs[4] = '{16'h7800, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 1'b0, 1'b1};
    vecs[6] = '{16'h07FF, 1'b0, 1'b1};
    vecs[7] = '{16'h0800, 1'b0, 1'b0};
    vecs[8] = '{16'hE000, 1'b0, 1'b0};
    vecs[9] = '{16'h6000, 1'b0, 1'b0};

    // Reset state, asynchronously before any clock edge
    #2;
    chk("reset strobes fw1", 16'(o[0]), 16'h0);
    chk("reset strobes fw3", 16'(o[1]), 16'h0);
    chk("reset instr", instr1, 16'h0);
    chk("reset count", cnt1, 16'h0);

    // Single-instruction table on FETCH_WAIT=1
    for (int i = 0; i < 10; i++) begin
      do_reset();
      go(vecs[i].op);
      @(negedge clk);
      chk($sformatf("v%0d fe", i), 16'(fe1), 16'h1);
      stop_go();
      @(negedge clk);
      chk($sformatf("v%0d e1", i), 16'(e11), 16'h1);
      chk($sformatf("v%0d instr", i), instr1, vecs[i].op);
      @(negedge clk);
      chk($sformatf("v%0d e2", i), 16'(e21), 16'(vecs[i].exp_e2));
      chk($sformatf("v%0d halted", i), 16'(h1), 16'(vecs[i].exp_halt));
      @(negedge clk);
      chk($sformatf("v%0d count", i), cnt1, 16'h1);
    end

    // Halt is absorbing for 20 cycles regardless of run, reset exits
    do_reset();
    go(16'h0000);
    @(negedge clk);
    stop_go();
    @(negedge clk);
    chk("halt e1", 16'(e11), 16'h1);
    for (int i = 0; i < 20; i++) begin
      run    = 1'($urandom_range(0, 1));
      imem_q = 16'($urandom);
      @(negedge clk);
      chk("halt hold", 16'(o[0]), 16'h1);
    end
    reset_n = 1'b0;
    #1 chk("halt reset", 16'(o[0]), 16'h0);
    run = 1'b0;
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("after halt idle", 16'(o[0]), 16'h0);

    // FETCH_WAIT=3: three fe cycles before e1
    do_reset();
    go(16'h8805);
    nfe = 0;
    for (int i = 0; i < 10 && !e13; i++) begin
      @(negedge clk);
`ifdef PHASE_SEQUENCER_STEP_EN
      step = 1'b0;
`endif
      if (fe3) nfe++;
    end
    chk("fw3 fe cycles", 16'(nfe), 16'd3);
    chk("fw3 e1", 16'(e13), 16'h1);
    chk("fw3 instr", instr3, 16'h8805);

    // Reset during the second fe cycle discards the instruction
    do_reset();
    go(16'hC003);
    @(negedge clk);
    stop_go();
    @(negedge clk);
    chk("fw3 2nd fe", 16'(fe3), 16'h1);
    reset_n = 1'b0;
    #1;
    chk("fw3 mid reset strobes", 16'(o[1]), 16'h0);
    chk("fw3 mid reset count", cnt3, 16'h0);
    chk("fw3 mid reset instr", instr3, 16'h0);
    #1 reset_n = 1'b1;

    // Counter wrap, starting close to the top
    do_reset();
    force dut1.count_q = 16'hFFF0;
    @(negedge clk);
    release dut1.count_q;
    for (int i = 0; i < 16; i++) begin
      go(16'h8805);
      @(negedge clk);
      stop_go();
      @(negedge clk);
      @(negedge clk);
      if (i == 14) chk("count top", cnt1, 16'hFFFF);
    end
    chk("count wrap", cnt1, 16'h0000);

`ifdef PHASE_SEQUENCER_STEP_EN
    do_reset();
    run = 1'b1;
    imem_q = 16'h8805;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("step idle", 16'(fe1), 16'h0);
    end
    step = 1'b1;
    @(negedge clk);
    chk("step fe", 16'(fe1), 16'h1);
    step = 1'b0;
    @(negedge clk);
    chk("step e1", 16'(e11), 16'h1);
    @(negedge clk);
    chk("step back idle", 16'(o[0]), 16'h0);
    chk("step count", cnt1, 16'h1);
`endif

    // Randomized run against the reference model
    do_reset();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rnd strobes fw%0d", FW[k]), 16'(o[k]), 16'(m_out(k)));
        chk($sformatf("rnd instr fw%0d", FW[k]), oi[k], m_instr[k]);
        chk($sformatf("rnd count fw%0d", FW[k]), oc[k], m_cnt[k]);
      end
      if ($urandom_range(0, 99) == 0) begin
        reset_n = 1'b0;
        m_reset();
        #1;
        chk("rnd async reset fw1", 16'(o[0]), 16'h0);
        chk("rnd async reset fw3", 16'(o[1]), 16'h0);
        #1 reset_n = 1'b1;
      end
      run = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 39))
        0:       imem_q = {5'b00000, 11'($urandom)};
        1, 2, 3, 4, 5, 6, 7, 8:
                 imem_q = {3'b110, 13'($urandom)};
        9, 10, 11, 12, 13, 14:
                 imem_q = {5'b01110, 11'($urandom)};
        default: imem_q = 16'($urandom) | 16'h0800;
      endcase
`ifdef PHASE_SEQUENCER_STEP_EN
      step = ($urandom_range(0, 3) == 0);
      m_step(step, 1'b0, imem_q);
`else
      m_step(run, run && !STEP, imem_q);
`endif
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
